// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_SHL = 2;
  localparam int unsigned OP_SHR = 3;
  localparam int unsigned OP_SRA = 4;
  localparam int unsigned OP_AND = 8;
  localparam int unsigned OP_OR  = 9;
  localparam int unsigned OP_XOR = 10;
  localparam int unsigned OP_MUL = 12;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned NFLAGS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// done and the product outputs are valid in the cycle of the last iteration.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] mplier;

  // Product including the current iteration, so the final value is visible with done.
  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    busy       = (cnt != '0);
    done       = (cnt == CW'(1));
    prod_lo    = acc_nxt[WIDTH-1:0];
    prod_hi_nz = |acc_nxt[PW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      cnt    <= CW'(WIDTH);
      acc    <= '0;
      mcand  <= {WIDTH'(0), a};
      mplier <= b;
    end else if (busy) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, one-entry output register, status flags
// and an iterative multiply; single-cycle ops sustain one result per clock.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [OPW-1:0]    opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [NFLAGS-1:0] flags,
  output logic              err
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned EW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_hi_nz;
  logic [WIDTH-1:0] mul_lo;

  logic [SW-1:0]    sh;
  logic [EW-1:0]    ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;

  logic              load;
  logic [WIDTH-1:0]  load_res;
  logic [NFLAGS-1:0] load_flags;
  logic              load_err;

  assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (opcode == OPW'(OP_MUL));
  assign mul_start = accept && is_mul;
  assign sh        = in2[SW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .a          (in1),
    .b          (in2),
    .busy       (mul_busy),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  // Single-cycle datapath; shifts use a one-bit extension to capture the last bit out.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OPW'(OP_ADD): begin
        ext     = {1'b0, in1} + {1'b0, in2};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (in1[MSB] == in2[MSB]) && (alu_res[MSB] != in1[MSB]);
      end
      OPW'(OP_SUB): begin
        alu_res = in1 - in2;
        alu_c   = (in1 < in2);
        alu_v   = (in1[MSB] != in2[MSB]) && (alu_res[MSB] != in1[MSB]);
      end
      OPW'(OP_SHL): begin
        ext     = {1'b0, in1} << sh;
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OPW'(OP_SHR): begin
        ext     = {in1, 1'b0} >> sh;
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      OPW'(OP_SRA): begin
        ext     = EW'($signed({in1, 1'b0}) >>> sh);
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      OPW'(OP_AND): alu_res = in1 & in2;
      OPW'(OP_OR):  alu_res = in1 | in2;
      OPW'(OP_XOR): alu_res = in1 ^ in2;
      OPW'(OP_MUL): alu_res = '0;
      default:      alu_err = 1'b1;
    endcase
  end

  // Next state plus selection of what the output register captures this edge.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_res   = alu_res;
    load_err   = alu_err;
    load_flags = '0;
    case (state)
      IDLE: begin
        if (mul_start) begin
          state_nxt = MUL;
        end else if (accept) begin
          load = 1'b1;
        end
        load_flags[FLAG_C] = alu_c;
        load_flags[FLAG_V] = alu_v;
      end
      MUL: begin
        load_res = mul_lo;
        load_err = 1'b0;
        load_flags[FLAG_C] = mul_hi_nz;
        if (mul_done || !mul_busy) begin
          state_nxt = IDLE;
          load      = mul_done;
        end
      end
      default: state_nxt = IDLE;
    endcase
    load_flags[FLAG_Z] = (load_res == '0);
    load_flags[FLAG_N] = load_res[MSB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register: reload wins over drain so back-to-back results keep full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      flags     <= load_flags;
      err       <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized stream,
// with a scoreboard of expected {err,flags,result} checked at every output handshake.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [3:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        err;

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 1'b0;
  logic [20:0] sbq[$];

  alu_pipe #(.WIDTH(16), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference behaviour, returned as {err, V, C, N, Z, result}.
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] r;
    logic c, v, e;
    int s;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    s = int'(b[3:0]);
    case (op)
      4'd0: begin p = 32'(a) + 32'(b); r = p[15:0]; c = p[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: begin r = a << s; if (s != 0) c = a[16-s]; end
      4'd3: begin r = a >> s; if (s != 0) c = a[s-1]; end
      4'd4: begin r = 16'($signed(a) >>> s); if (s != 0) c = a[s-1]; end
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      4'd12: begin p = 32'(a) * 32'(b); r = p[15:0]; c = |p[31:16]; end
      default: e = 1'b1;
    endcase
    return {e, v, c, r[15], (r == 16'h0), r};
  endfunction

  task automatic monitor();
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got err=%b flags=%h result=%h with empty scoreboard", err, flags, result);
        end else begin
          e = sbq.pop_front();
          if ({err, flags, result} !== e) begin
            bad++;
            $display("FAIL sb_compare got err=%b flags=%h result=%h exp err=%b flags=%h result=%h",
                     err, flags, result, e[20], e[19:16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic rdy_randomizer();
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Presents one operation, waits (bounded) for acceptance; returns at accept edge + 1.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
    int n;
    n = 0;
    opcode = op; in1 = a; in2 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout op=%0d in_ready=%b after %0d cycles, need 1", op, in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) sbq.push_back(model(op, a, b));
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b need 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b need 0", out_valid); end
    total++; if ({err, flags, result} !== 21'h0) begin bad++; $display("FAIL rst_outputs got err=%b flags=%h result=%h need 0", err, flags, result); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b need 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pre_valid got %b need 0", out_valid); end
    send(4'd0, 16'hFFFF, 16'h0001, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency out_valid got %b need 1", out_valid); end
    total++; if ({err, flags, result} !== {1'b0, 4'h5, 16'h0000}) begin bad++; $display("FAIL add_wrap got flags=%h result=%h need flags=5 result=0000", flags, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    send(4'd1, 16'h8000, 16'h0001, 1'b1);
    total++; if ({flags, result} !== {4'h8, 16'h7FFF}) begin bad++; $display("FAIL sub_ovf got flags=%h result=%h need flags=8 result=7fff", flags, result); end
    @(posedge clk); #1;
    send(4'd1, 16'h0001, 16'h0002, 1'b1);
    total++; if ({flags, result} !== {4'h6, 16'hFFFF}) begin bad++; $display("FAIL sub_borrow got flags=%h result=%h need flags=6 result=ffff", flags, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n;
    n = 0;
    send(4'd12, 16'h0100, 16'h0101, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_busy_ready cycle %0d got %b need 0", n, in_ready); end
      opcode = 4'd0; in1 = 16'h0001; in2 = 16'h0001;
      in_valid = (n % 2 == 1);
    end
    in_valid = 1'b0;
    total++; if (n != 16) begin bad++; $display("FAIL mul_latency got %0d need 16", n); end
    total++; if ({err, flags, result} !== {1'b0, 4'h4, 16'h0100}) begin bad++; $display("FAIL mul_value got flags=%h result=%h need flags=4 result=0100", flags, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_shift_illegal();
    send(4'd4, 16'h8001, 16'h0011, 1'b1);
    total++; if ({flags, result} !== {4'h6, 16'hC000}) begin bad++; $display("FAIL sra got flags=%h result=%h need flags=6 result=c000", flags, result); end
    @(posedge clk); #1;
    send(4'd2, 16'h1234, 16'h0000, 1'b1);
    total++; if ({flags, result} !== {4'h0, 16'h1234}) begin bad++; $display("FAIL shl0 got flags=%h result=%h need flags=0 result=1234", flags, result); end
    @(posedge clk); #1;
    send(4'd5, 16'h1234, 16'h0005, 1'b1);
    total++; if ({err, flags, result} !== {1'b1, 4'h1, 16'h0000}) begin bad++; $display("FAIL illegal got err=%b flags=%h result=%h need err=1 flags=1 result=0000", err, flags, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd0, 16'h0011, 16'h0022, 1'b1);
    opcode = 4'd0; in1 = 16'h0100; in2 = 16'h0200; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cycle %0d got %b need 0", i, in_ready); end
      total++; if ({out_valid, flags, result} !== {1'b1, 4'h0, 16'h0033}) begin bad++; $display("FAIL bp_hold got valid=%b flags=%h result=%h need 1/0/0033", out_valid, flags, result); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b need 1", in_ready); end
    @(posedge clk);
    sbq.push_back(model(4'd0, 16'h0100, 16'h0200));
    #1;
    in_valid = 1'b0;
    total++; if ({out_valid, result} !== {1'b1, 16'h0300}) begin bad++; $display("FAIL bp_second got valid=%b result=%h need 1/0300", out_valid, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    seen = 1'b0;
    out_ready = 1'b1;
    send(4'd12, 16'h1234, 16'h5678, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got %b need 0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b need 0", out_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got %b need 1", in_ready); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_ghost got out_valid=1 after abandoned mul, need 0"); end
    @(posedge clk); #1;
    send(4'd0, 16'h0003, 16'h0004, 1'b1);
    total++; if (result !== 16'h0007) begin bad++; $display("FAIL midrst_add got %h need 0007", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [12];
    int n;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd12, 4'd5, 4'd7, 4'd15};
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(ops[$urandom_range(0, 11)], 16'($urandom), 16'($urandom), 1'b1);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL b2b_drain got %0d pending need 0", sbq.size()); end
  endtask

  initial begin
    fork
      monitor();
      rdy_randomizer();
    join_none
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_shift_illegal();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
